// File: rtl/ace_req_responder.sv
// Interconnect-side responder: accepts cache-controller line requests, applies a fixed latency
// against a small backing store and returns a one-cycle ace_ready with fill data and install state.
// Optional per-op request counters are built when ACE_RESP_STATS_EN is defined.
module ace_req_responder #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 16,
  parameter int RD_LATENCY = 4,
  parameter int WR_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read_req,
  input  logic              write_req,
  input  logic              invalid_req,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              shared_hint,
  output logic              ace_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [2:0]        resp_state,
  output logic              busy
`ifdef ACE_RESP_STATS_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count,
  output logic [15:0]       inv_count
`endif
);

  // state  | meaning
  // S_IDLE | waiting for a request; highest priority one is accepted
  // S_WAIT | latency countdown for the accepted op
  // S_RESP | ace_ready cycle; requester drops the served request
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_INVAL} op_e;

  localparam int IDX_W   = $clog2(DEPTH);
  localparam int LAT_MAX = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LATENCY - 1);

  localparam logic [2:0] ST_UC = 3'b000;
  localparam logic [2:0] ST_SC = 3'b010;
  localparam logic [2:0] ST_I  = 3'b100;

  state_e            state;
  op_e               op;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] wdata;
  logic              shared;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  // Store index aliases on the low address bits only.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[ADDR_W-1:IDX_W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      op         <= OP_READ;
      idx        <= '0;
      wdata      <= '0;
      shared     <= 1'b0;
      cnt        <= '0;
      ace_ready  <= 1'b0;
      busy       <= 1'b0;
      resp_data  <= '0;
      resp_state <= ST_I;
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else begin
      ace_ready <= 1'b0;
      case (state)
        S_IDLE: begin
          if (write_req || invalid_req || read_req) begin
            idx    <= req_addr[IDX_W-1:0];
            wdata  <= req_wdata;
            shared <= shared_hint;
            busy   <= 1'b1;
            state  <= S_WAIT;
            if (write_req) begin
              op  <= OP_WRITE;
              cnt <= WR_LOAD;
            end else if (invalid_req) begin
              op  <= OP_INVAL;
              cnt <= WR_LOAD;
            end else begin
              op  <= OP_READ;
              cnt <= RD_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            // Effects land on the same edge that raises ace_ready.
            state     <= S_RESP;
            ace_ready <= 1'b1;
            case (op)
              OP_READ: begin
                resp_data  <= mem[idx];
                resp_state <= shared ? ST_SC : ST_UC;
              end
              OP_WRITE: begin
                mem[idx]   <= wdata;
                resp_state <= ST_I;
              end
              default: resp_state <= ST_UC;
            endcase
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ACE_RESP_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_count  <= '0;
      wr_count  <= '0;
      inv_count <= '0;
    end else if (state == S_WAIT && cnt == '0) begin
      case (op)
        OP_READ:  if (rd_count  != 16'hFFFF) rd_count  <= rd_count  + 16'd1;
        OP_WRITE: if (wr_count  != 16'hFFFF) wr_count  <= wr_count  + 16'd1;
        default:  if (inv_count != 16'hFFFF) inv_count <= inv_count + 16'd1;
      endcase
    end
  end
`endif

endmodule
